fsm_frame_scheduler: RTL and testbench

//  Shares one 4-state Mealy sequence detector (states AC/BD/E/F, input x, output Z) between NREQ requesters.

---
 rtl/fsm_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_fsm_frame_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_frame_scheduler.sv
// Round-robin scheduler that shares one Mealy sequence detector (AC/BD/E/F) among NREQ requesters.
// Each granted frame is shifted LSB-first through the detector; the per-bit Z mask and its popcount are returned.
module fsm_frame_scheduler #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int IDX_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*FRAME_W-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [FRAME_W-1:0]      res_zmask,
  output logic [CNT_W-1:0]        res_count,
  output logic                    busy,
  output logic [3:0]              det_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] DET_AC = 4'b0001;
  localparam logic [3:0] DET_BD = 4'b0010;
  localparam logic [3:0] DET_E  = 4'b0100;
  localparam logic [3:0] DET_F  = 4'b1000;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NREQ - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         det_q, det_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] zmask_q, zmask_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic               x;
  logic               z;
  logic [3:0]         det_nxt;

  // Search starts one past the last granted index, so the pointer reset value of NREQ-1 favours req 0 first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!grant_found && req_valid[(32'(ptr_q) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    x       = frame_q[idx_q];
    z       = 1'b0;
    det_nxt = DET_AC;
    case (det_q)
      DET_AC: begin det_nxt = x ? DET_BD : DET_E;  z = x;    end
      DET_BD: begin det_nxt = x ? DET_BD : DET_F;  z = 1'b0; end
      DET_E:  begin det_nxt = x ? DET_F  : DET_AC; z = x;    end
      DET_F:  begin det_nxt = x ? DET_AC : DET_BD; z = 1'b0; end
      default: begin det_nxt = DET_AC; z = 1'b0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    frame_d   = frame_q;
    zmask_d   = zmask_q;
    count_d   = count_q;
    idx_d     = idx_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          frame_d = req_data[int'(grant_idx) * FRAME_W +: FRAME_W];
          id_d    = grant_idx;
          zmask_d = '0;
          count_d = '0;
          det_d   = DET_AC;
          idx_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        zmask_d[idx_q] = z;
        count_d = count_q + CNT_W'(z);
        det_d   = det_nxt;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          ptr_d   = id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      det_q   <= DET_AC;
      frame_q <= '0;
      zmask_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      frame_q <= frame_d;
      zmask_q <= zmask_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_id    = id_q;
  assign res_zmask = zmask_q;
  assign res_count = count_q;
  assign det_state = det_q;

endmodule

// File: tb/tb_fsm_frame_scheduler.sv
// Directed bench for fsm_frame_scheduler: table of single-requester frames plus
// hand-written sequences for round-robin, result back-pressure and mid-frame reset.
module tb_fsm_frame_scheduler;

  localparam int NREQ    = 4;
  localparam int FRAME_W = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*FRAME_W-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic [FRAME_W-1:0]      res_zmask;
  logic [CNT_W-1:0]        res_count;
  logic                    busy;
  logic [3:0]              det_state;

  fsm_frame_scheduler #(
    .NREQ(NREQ),
    .FRAME_W(FRAME_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id(res_id),
    .res_zmask(res_zmask),
    .res_count(res_count),
    .busy(busy),
    .det_state(det_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    logic [7:0]  data;
    logic [7:0]  zmask;
    logic [3:0]  count;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where res_valid is first seen.
  task automatic wait_res(output int n, output bit seen);
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("res_valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic run_frame(input int unsigned id, input logic [7:0] data,
                           input logic [7:0] ezm, input logic [3:0] ecnt);
    int n;
    bit seen;
    @(negedge clk);
    req_data[id*8 +: 8] = data;
    req_valid = 4'(1 << id);
    res_ready = 1'b1;
    #1;
    seen = 1'b0;
    for (n = 0; n < 50; n++) begin
      if (req_ready != 0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("grant_timeout", 32'(seen), 32'd1);
    check("grant_onehot", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    check("busy_in_shift", 32'(busy), 32'd1);
    wait_res(n, seen);
    // First negedge after the accept edge is n=1; the detector needs FRAME_W shift edges.
    check("latency", 32'(n), 32'(FRAME_W + 1));
    check("res_id", 32'(res_id), 32'(id));
    check("res_zmask", 32'(res_zmask), 32'(ezm));
    check("res_count", 32'(res_count), 32'(ecnt));
    @(negedge clk);
    check("res_valid_drop", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    int  grants;
    int  last_cyc;

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_det_state", 32'(det_state), 32'h1);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    check("rst_res_zmask", 32'(res_zmask), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Hand-traced through the detector table, LSB first, starting at AC.
    vecs[0] = '{0, 8'hFF, 8'h01, 4'd1};
    vecs[1] = '{0, 8'h00, 8'h00, 4'd0};
    vecs[2] = '{1, 8'hAA, 8'h82, 4'd2};
    vecs[3] = '{2, 8'h55, 8'h11, 4'd2};
    vecs[4] = '{1, 8'h0F, 8'h01, 4'd1};
    vecs[5] = '{2, 8'hF0, 8'h10, 4'd1};
    vecs[6] = '{0, 8'hB6, 8'h92, 4'd3};
    vecs[7] = '{3, 8'h00, 8'h00, 4'd0};
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].id, vecs[i].data, vecs[i].zmask, vecs[i].count);
    end

    // Round robin: last grant was req 3, so all-valid grants run 0,1,2,3,0,1,2,3.
    @(negedge clk);
    req_data  = {8'h00, 8'h55, 8'hAA, 8'hFF};
    req_valid = 4'hF;
    res_ready = 1'b1;
    grants    = 0;
    last_cyc  = 0;
    for (int cyc = 0; cyc < 200 && grants < 8; cyc++) begin
      #1;
      if (req_ready != 0) begin
        check("rr_grant", 32'(req_ready), 32'(1 << (grants % 4)));
        if (grants > 0) check("rr_period", 32'(cyc - last_cyc), 32'(FRAME_W + 2));
        last_cyc = cyc;
        grants++;
      end
      @(negedge clk);
    end
    check("rr_grant_count", 32'(grants), 32'd8);
    req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rr_drain", 32'(seen), 32'd1);

    // Back-pressure: result held while res_ready is low; pending req 2 is not granted.
    @(negedge clk);
    req_data[15:8] = 8'hAA;
    req_data[23:16] = 8'h55;
    req_valid = 4'b0010;
    res_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_res(n, seen);
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_id", 32'(res_id), 32'd1);
      check("bp_res_zmask", 32'(res_zmask), 32'h82);
      check("bp_res_count", 32'(res_count), 32'd2);
      check("bp_no_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_released", 32'(res_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_res(n, seen);
    check("bp_next_zmask", 32'(res_zmask), 32'h11);
    check("bp_next_id", 32'(res_id), 32'd2);
    @(negedge clk);

    // Mid-frame reset at idx 3: frame abandoned, pointer back to favouring req 0.
    @(negedge clk);
    req_data[31:24] = 8'hFF;
    req_valid = 4'b1000;
    #1;
    check("mr_grant", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("mr_busy_before", 32'(busy), 32'd1);
    check("mr_det_before", 32'(det_state), 32'h2);
    reset = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_res_valid", 32'(res_valid), 32'd0);
    check("mr_det_state", 32'(det_state), 32'h1);
    check("mr_res_count", 32'(res_count), 32'd0);
    @(negedge clk);
    check("mr_busy_next", 32'(busy), 32'd0);
    reset = 1'b0;
    req_data  = {8'hFF, 8'h55, 8'hAA, 8'h55};
    req_valid = 4'hF;
    #1;
    check("mr_next_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_res(n, seen);
    check("mr_res_id", 32'(res_id), 32'd0);
    check("mr_res_zmask", 32'(res_zmask), 32'h11);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
